// File: rtl/ps2_tx_multi_pkg.sv
// Shared definitions for the multi-channel PS/2 device-side transmitter:
// frame state encoding, line levels and a port-width helper.
package ps2_tx_multi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_D0   = 4'd1,
    ST_D1   = 4'd2,
    ST_D2   = 4'd3,
    ST_D3   = 4'd4,
    ST_D4   = 4'd5,
    ST_D5   = 4'd6,
    ST_D6   = 4'd7,
    ST_D7   = 4'd8,
    ST_PAR  = 4'd9,
    ST_STOP = 4'd10,
    ST_GAP  = 4'd11
  } tx_state_e;

  localparam logic PS2_START = 1'b0;
  localparam logic PS2_STOP  = 1'b1;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_tx_multi_chan.sv
// One PS/2 transmit channel: byte FIFO with sticky overflow, plus the frame
// FSM that shifts start, 8 data bits LSB first, odd parity and stop on each tick.
module ps2_tx_multi_chan
  import ps2_tx_multi_pkg::*;
#(
  parameter int FIFO_BITS = 3,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       tick_i,
  input  logic       clk_ps2_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       enable_i,
  input  logic       ovf_clr_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o,
  output logic       busy_o,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);

  localparam int DEPTH = 2 ** FIFO_BITS;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_BITS-1:0] wptr_q, rptr_q;
  logic [FIFO_BITS:0]   count_q;
  logic                 overflow_q;
  logic                 push, pop, drop;

  tx_state_e  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic       parity_q, parity_d;
  logic       data_q, data_d;
  logic [3:0] gap_q, gap_d;

  assign full_o  = count_q[FIFO_BITS];
  assign empty_o = (count_q == '0);

  // A pop in the same cycle frees the slot, so a write at full is still accepted.
  assign pop  = tick_i & (state_q == ST_IDLE) & ~empty_o & enable_i;
  assign push = wr_en_i & (~full_o | pop);
  assign drop = wr_en_i & full_o & ~pop;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)           overflow_q <= 1'b1;
      else if (ovf_clr_i) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      data_q   <= PS2_STOP;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    data_d   = data_q;
    gap_d    = gap_q;
    if (tick_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shreg_d  = mem_q[rptr_q];
            parity_d = 1'b1;
            data_d   = PS2_START;
            state_d  = ST_D0;
          end
        end
        ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
          data_d   = shreg_q[0];
          shreg_d  = {1'b0, shreg_q[7:1]};
          parity_d = parity_q ^ shreg_q[0];
          state_d  = (state_q == ST_D7) ? ST_PAR : tx_state_e'(state_q + 4'd1);
        end
        ST_PAR: begin
          data_d  = parity_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          data_d  = PS2_STOP;
          gap_d   = '0;
          state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == 4'(GAP_TICKS - 1)) state_d = ST_IDLE;
          else                            gap_d   = gap_q + 4'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign ps2_clk_o  = clk_ps2_i | (state_q == ST_IDLE) | (state_q == ST_GAP);
  assign ps2_data_o = data_q;

endmodule

// File: rtl/ps2_tx_multi.sv
// N-channel PS/2 device-side transmitter: shared clk_ps2 divider and write
// demux feeding one FIFO + frame FSM per channel.
module ps2_tx_multi
  import ps2_tx_multi_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100,
  parameter int GAP_TICKS = 1
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          wr_stb,
  input  logic [ch_width(CHANNELS)-1:0] wr_ch,
  input  logic [7:0]                    wr_data,
  input  logic [CHANNELS-1:0]           ch_enable,
  output logic [CHANNELS-1:0]           fifo_full,
  output logic [CHANNELS-1:0]           fifo_empty,
  output logic [CHANNELS-1:0]           overflow,
  input  logic [CHANNELS-1:0]           ovf_clr,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           ps2_clk,
  output logic [CHANNELS-1:0]           ps2_data
);

  localparam int CHW  = ch_width(CHANNELS);
  localparam int CNTW = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            clk_ps2_q, clk_ps2_d;
  logic            tick;

  always_comb begin
    cnt_d     = cnt_q + CNTW'(1);
    clk_ps2_d = clk_ps2_q;
    if (cnt_q == CNTW'(PS2DIV)) begin
      cnt_d     = '0;
      clk_ps2_d = ~clk_ps2_q;
    end
  end

  // Frames advance on the rising edge of clk_ps2 so data is stable at the falling edge.
  assign tick = (cnt_q == CNTW'(PS2DIV)) & ~clk_ps2_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q     <= '0;
      clk_ps2_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_ps2_q <= clk_ps2_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic wr_en;
    assign wr_en = wr_stb & (wr_ch == CHW'(gi));

    ps2_tx_multi_chan #(
      .FIFO_BITS (FIFO_BITS),
      .GAP_TICKS (GAP_TICKS)
    ) u_chan (
      .clk_i      (clk_sys),
      .srst_i     (reset),
      .tick_i     (tick),
      .clk_ps2_i  (clk_ps2_q),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .enable_i   (ch_enable[gi]),
      .ovf_clr_i  (ovf_clr[gi]),
      .full_o     (fifo_full[gi]),
      .empty_o    (fifo_empty[gi]),
      .overflow_o (overflow[gi]),
      .busy_o     (busy[gi]),
      .ps2_clk_o  (ps2_clk[gi]),
      .ps2_data_o (ps2_data[gi])
    );
  end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Directed bench for ps2_tx_multi: 3 channels, depth 8, PS2DIV=1 (clk_ps2 period
// of 4 clk_sys cycles), one gap tick. Frames are captured on ps2_clk falling edges.
module tb_ps2_tx_multi;

  localparam int CH = 3;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          wr_stb;
  logic [1:0]    wr_ch;
  logic [7:0]    wr_data;
  logic [CH-1:0] ch_enable;
  logic [CH-1:0] fifo_full, fifo_empty, overflow, ovf_clr, busy, ps2_clk, ps2_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc;

  // Frame words: bit0 = start, bits 8:1 = data LSB first, bit9 = odd parity.
  logic [7:0]  t2_bytes [8] = '{8'h01, 8'h02, 8'h03, 8'h80, 8'h7F, 8'hF0, 8'h00, 8'h3C};
  logic [31:0] t2_exp   [8] = '{32'h002, 32'h004, 32'h206, 32'h100, 32'h0FE, 32'h3E0, 32'h200, 32'h278};
  logic [7:0]  t4_bytes [3] = '{8'h11, 8'h22, 8'h33};
  logic [31:0] t4_exp   [3] = '{32'h222, 32'h244, 32'h266};

  ps2_tx_multi #(
    .CHANNELS  (CH),
    .FIFO_BITS (3),
    .PS2DIV    (1),
    .GAP_TICKS (1)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .wr_stb     (wr_stb),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .ch_enable  (ch_enable),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .busy       (busy),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  always #5 clk_sys = ~clk_sys;

  // Cycles since the last sampled reset; ticks land on posedges where cyc%4==1 beforehand.
  always @(posedge clk_sys) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [1:0] ch, input logic [7:0] d);
    wr_stb  = 1'b1;
    wr_ch   = ch;
    wr_data = d;
    @(negedge clk_sys);
    wr_stb  = 1'b0;
  endtask

  task automatic capture(input logic [1:0] mask, output logic [9:0] f0, output logic [9:0] f1,
                         output int first0, output int last0, output int first1);
    int n0 = 0;
    int n1 = 0;
    logic [1:0] prev;
    logic done;
    f0 = '0; f1 = '0; first0 = 0; last0 = 0; first1 = 0;
    prev = ps2_clk[1:0];
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk_sys);
      if (mask[0] && n0 < 10 && prev[0] && !ps2_clk[0]) begin
        f0[n0] = ps2_data[0];
        if (n0 == 0) first0 = cyc;
        if (n0 == 9) last0 = cyc;
        n0++;
      end
      if (mask[1] && n1 < 10 && prev[1] && !ps2_clk[1]) begin
        f1[n1] = ps2_data[1];
        if (n1 == 0) first1 = cyc;
        n1++;
      end
      prev = ps2_clk[1:0];
      done = (!mask[0] || n0 == 10) && (!mask[1] || n1 == 10);
    end
    check("capture_done", 32'(done), 32'd1);
  endtask

  initial begin
    logic [9:0] fa, fb;
    int fst0, lst0, fst1, prev_last, falls;
    logic quiet_bad, pc;

    reset = 1'b1; wr_stb = 1'b0; wr_ch = '0; wr_data = '0;
    ch_enable = 3'b111; ovf_clr = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_empty",    32'(fifo_empty), 32'h7);
    check("rst_full",     32'(fifo_full),  32'h0);
    check("rst_overflow", 32'(overflow),   32'h0);
    check("rst_busy",     32'(busy),       32'h0);
    check("rst_ps2_clk",  32'(ps2_clk),    32'h7);
    check("rst_ps2_data", 32'(ps2_data),   32'h7);
    reset = 1'b0;
    @(negedge clk_sys);

    // 1: single byte 0x1C on ch0
    write_byte(2'd0, 8'h1C);
    capture(2'b01, fa, fb, fst0, lst0, fst1);
    check("t1_frame", 32'(fa), 32'h038);
    repeat (4) @(negedge clk_sys);
    check("t1_stop_bit",  32'(ps2_data[0]), 32'd1);
    check("t1_gap_busy",  32'(busy[0]),     32'd1);
    check("t1_gap_clk",   32'(ps2_clk[0]),  32'd1);
    repeat (4) @(negedge clk_sys);
    check("t1_idle_busy", 32'(busy[0]),     32'd0);

    // 2: fill ch1, overflow, clear, drain in order
    ch_enable[1] = 1'b0;
    for (int i = 0; i < 8; i++) write_byte(2'd1, t2_bytes[i]);
    check("t2_full8",  32'(fifo_full[1]), 32'd1);
    check("t2_noovf8", 32'(overflow[1]),  32'd0);
    write_byte(2'd1, 8'hEE);
    check("t2_ovf9",   32'(overflow[1]),  32'd1);
    check("t2_full9",  32'(fifo_full[1]), 32'd1);
    ovf_clr[1] = 1'b1;
    @(negedge clk_sys);
    ovf_clr[1] = 1'b0;
    check("t2_ovf_clr", 32'(overflow[1]), 32'd0);
    ch_enable[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      capture(2'b10, fa, fb, fst0, lst0, fst1);
      check($sformatf("t2_frame%0d", i), 32'(fb), t2_exp[i]);
    end
    check("t2_drained", 32'(fifo_empty[1]), 32'd1);

    // 3: both channels start on the same tick
    repeat (12) @(negedge clk_sys);
    ch_enable = 3'b100;
    write_byte(2'd0, 8'hAA);
    write_byte(2'd1, 8'h55);
    ch_enable = 3'b111;
    capture(2'b11, fa, fb, fst0, lst0, fst1);
    check("t3_ch0", 32'(fa), 32'h354);
    check("t3_ch1", 32'(fb), 32'h2AA);
    check("t3_same_tick", 32'(fst1), 32'(fst0));

    // 4: disabled channel holds bytes; enable sends them with one idle period between
    repeat (12) @(negedge clk_sys);
    ch_enable[0] = 1'b0;
    for (int i = 0; i < 3; i++) write_byte(2'd0, t4_bytes[i]);
    check("t4_queued", 32'(fifo_empty[0]), 32'd0);
    quiet_bad = 1'b0;
    repeat (40) begin
      @(negedge clk_sys);
      if (!ps2_clk[0] || busy[0]) quiet_bad = 1'b1;
    end
    check("t4_quiet", 32'(quiet_bad), 32'd0);
    ch_enable[0] = 1'b1;
    prev_last = 0;
    for (int i = 0; i < 3; i++) begin
      capture(2'b01, fa, fb, fst0, lst0, fst1);
      check($sformatf("t4_frame%0d", i), 32'(fa), t4_exp[i]);
      if (i > 0) check($sformatf("t4_spacing%0d", i), 32'(fst0 - prev_last), 32'd12);
      prev_last = lst0;
    end

    // 6: out-of-range channel ignored; write+pop at full keeps it full
    repeat (12) @(negedge clk_sys);
    write_byte(2'd3, 8'h99);
    check("t6_badch_empty", 32'(fifo_empty), 32'h7);
    check("t6_badch_ovf",   32'(overflow),   32'h0);
    check("t6_badch_full",  32'(fifo_full),  32'h0);
    ch_enable[0] = 1'b0;
    for (int i = 0; i < 8; i++) write_byte(2'd0, 8'h40 + 8'(i));
    check("t6_full", 32'(fifo_full[0]), 32'd1);
    for (int t = 0; t < 8 && (cyc % 4) != 1; t++) @(negedge clk_sys);
    ch_enable[0] = 1'b1;
    write_byte(2'd0, 8'h48);
    ch_enable[0] = 1'b0;
    check("t6_wp_full", 32'(fifo_full[0]), 32'd1);
    check("t6_wp_ovf",  32'(overflow[0]),  32'd0);
    check("t6_wp_busy", 32'(busy[0]),      32'd1);

    // 5: reset in the middle of a 0xFF frame
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    ch_enable = 3'b001;
    for (int i = 0; i < 9; i++) write_byte(2'd1, 8'(i));
    check("t5_ovf_set", 32'(overflow[1]), 32'd1);
    write_byte(2'd0, 8'hFF);
    write_byte(2'd0, 8'h12);
    falls = 0;
    pc = ps2_clk[0];
    for (int t = 0; t < 100 && falls < 3; t++) begin
      @(negedge clk_sys);
      if (pc && !ps2_clk[0]) falls++;
      pc = ps2_clk[0];
    end
    check("t5_falls", 32'(falls), 32'd3);
    repeat (2) @(negedge clk_sys);
    check("t5_mid_busy", 32'(busy[0]),     32'd1);
    check("t5_mid_data", 32'(ps2_data[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("t5_rst_clk",   32'(ps2_clk),    32'h7);
    check("t5_rst_data",  32'(ps2_data),   32'h7);
    check("t5_rst_empty", 32'(fifo_empty), 32'h7);
    check("t5_rst_ovf",   32'(overflow),   32'h0);
    check("t5_rst_busy",  32'(busy),       32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk_sys);
    check("t5_after_clk",  32'(ps2_clk),    32'h7);
    check("t5_after_busy", 32'(busy),       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
